reg_exe_stage: RTL

//  Decode->Execute pipeline register with load-use hazard detection. Captures decoded fields
//  (Ra/Rb/Robj, read/write enables, memory controls, operands) and presents them as *_Reg_Exe to
//  the forwarding unit and ALU. A load followed by a consumer of its result cannot be forwarded,
//  so this stage stalls fetch/decode and injects bubbles. Branch flush and memory hold also land here.

---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/reg_exe_stage_if.sv | 37 +++
 rtl/reg_exe_stage_detector.sv | 75 +++++++
 rtl/reg_exe_stage.sv | 75 +++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the decode->execute boundary: register index width,
// FSM state encoding and the control bundle carried into Exe.
package pipeline_pkg;

  localparam int REG_W = 4;

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] STALL = 1'b1;

  typedef struct packed {
    logic [REG_W-1:0] Ra;
    logic             RE_A;
    logic [REG_W-1:0] Rb;
    logic             RE_B;
    logic [REG_W-1:0] Robj;
    logic             WE;
    logic             mem_WE;
    logic             mem_RE;
  } ctrl_t;

  // A bubble clears every enable, so downstream forwarding sees nothing to match.
  localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/reg_exe_stage_if.sv
// Decode->Execute boundary: decoded fields in, registered Exe copies and stall out.
interface reg_exe_stage_if #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 4
);
  import pipeline_pkg::*;

  logic              hold;
  logic              flush;
  logic [REG_W-1:0]  Ra_F_Reg,     Rb_F_Reg,     Robj_F_Reg;
  logic              RE_A_F_Reg,   RE_B_F_Reg,   WE_F_Reg;
  logic              mem_WE_F_Reg, mem_RE_F_Reg;
  logic [OP_W-1:0]   alu_op_F_Reg;
  logic [DATA_W-1:0] dataA_F_Reg,  dataB_F_Reg;

  logic [REG_W-1:0]  Ra_Reg_Exe,     Rb_Reg_Exe,     Robj_Reg_Exe;
  logic              RE_A_Reg_Exe,   RE_B_Reg_Exe,   WE_Reg_Exe;
  logic              mem_WE_Reg_Exe, mem_RE_Reg_Exe;
  logic [OP_W-1:0]   alu_op_Reg_Exe;
  logic [DATA_W-1:0] dataA_Reg_Exe,  dataB_Reg_Exe;
  logic              stall;

  modport master (
    output hold, flush, Ra_F_Reg, Rb_F_Reg, Robj_F_Reg, RE_A_F_Reg, RE_B_F_Reg, WE_F_Reg,
           mem_WE_F_Reg, mem_RE_F_Reg, alu_op_F_Reg, dataA_F_Reg, dataB_F_Reg,
    input  Ra_Reg_Exe, Rb_Reg_Exe, Robj_Reg_Exe, RE_A_Reg_Exe, RE_B_Reg_Exe, WE_Reg_Exe,
           mem_WE_Reg_Exe, mem_RE_Reg_Exe, alu_op_Reg_Exe, dataA_Reg_Exe, dataB_Reg_Exe, stall
  );

  modport slave (
    input  hold, flush, Ra_F_Reg, Rb_F_Reg, Robj_F_Reg, RE_A_F_Reg, RE_B_F_Reg, WE_F_Reg,
           mem_WE_F_Reg, mem_RE_F_Reg, alu_op_F_Reg, dataA_F_Reg, dataB_F_Reg,
    output Ra_Reg_Exe, Rb_Reg_Exe, Robj_Reg_Exe, RE_A_Reg_Exe, RE_B_Reg_Exe, WE_Reg_Exe,
           mem_WE_Reg_Exe, mem_RE_Reg_Exe, alu_op_Reg_Exe, dataA_Reg_Exe, dataB_Reg_Exe, stall
  );

endinterface

// File: rtl/reg_exe_stage_detector.sv
// Load-use hazard comparator plus RUN/STALL FSM; emits stall and the bubble request.
// hold freezes the FSM and asserts stall; flush cancels any pending stall.
module load_use_detector
  import pipeline_pkg::*;
#(
  parameter int LOAD_STALL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_hold,
  input  logic             i_flush,
  input  logic [REG_W-1:0] i_ra,
  input  logic             i_re_a,
  input  logic [REG_W-1:0] i_rb,
  input  logic             i_re_b,
  input  logic [REG_W-1:0] i_exe_robj,
  input  logic             i_exe_we,
  input  logic             i_exe_mem_re,
  output logic             o_stall,
  output logic             o_insert_bubble
);

  localparam logic [1:0] STALL_CNT = 2'(LOAD_STALL - 1);

  logic [0:0] r_state, w_state_nxt;
  logic [1:0] r_cnt,   w_cnt_nxt;
  logic       w_haz;

  assign w_haz = i_exe_mem_re & i_exe_we &
                 ((i_re_a & (i_ra == i_exe_robj)) | (i_re_b & (i_rb == i_exe_robj)));

  // r_cnt is the number of STALL-state cycles still to come, the current one included.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    o_stall         = 1'b0;
    o_insert_bubble = 1'b0;
    if (!rst) begin
      if (i_hold) begin
        o_stall = 1'b1;
      end else if (i_flush) begin
        o_insert_bubble = 1'b1;
        w_state_nxt     = RUN;
        w_cnt_nxt       = 2'd0;
      end else if (r_state == RUN) begin
        if (w_haz) begin
          o_stall         = 1'b1;
          o_insert_bubble = 1'b1;
          w_cnt_nxt       = STALL_CNT;
          w_state_nxt     = (STALL_CNT == 2'd0) ? RUN : STALL;
        end
      end else begin
        o_stall         = 1'b1;
        o_insert_bubble = 1'b1;
        if (r_cnt <= 2'd1) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = 2'd0;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/reg_exe_stage.sv
// Decode->Execute pipeline register, 1-cycle latency; stalls decode on load-use hazards.
// Priority per edge: rst > hold (freeze) > flush/hazard (bubble) > capture.
module reg_exe_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int OP_W       = 4,
  parameter int LOAD_STALL = 1
) (
  input logic           clk,
  input logic           rst,
  reg_exe_stage_if.slave bus
);

  ctrl_t             r_ctrl, w_ctrl_in;
  logic [OP_W-1:0]   r_alu_op;
  logic [DATA_W-1:0] r_data_a, r_data_b;
  logic              w_bubble, w_stall;

  assign w_ctrl_in = '{Ra:     bus.Ra_F_Reg,     RE_A:   bus.RE_A_F_Reg,
                       Rb:     bus.Rb_F_Reg,     RE_B:   bus.RE_B_F_Reg,
                       Robj:   bus.Robj_F_Reg,   WE:     bus.WE_F_Reg,
                       mem_WE: bus.mem_WE_F_Reg, mem_RE: bus.mem_RE_F_Reg};

  load_use_detector #(.LOAD_STALL(LOAD_STALL)) u_detector (
    .clk             (clk),
    .rst             (rst),
    .i_hold          (bus.hold),
    .i_flush         (bus.flush),
    .i_ra            (bus.Ra_F_Reg),
    .i_re_a          (bus.RE_A_F_Reg),
    .i_rb            (bus.Rb_F_Reg),
    .i_re_b          (bus.RE_B_F_Reg),
    .i_exe_robj      (r_ctrl.Robj),
    .i_exe_we        (r_ctrl.WE),
    .i_exe_mem_re    (r_ctrl.mem_RE),
    .o_stall         (w_stall),
    .o_insert_bubble (w_bubble)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl   <= BUBBLE;
      r_alu_op <= '0;
      r_data_a <= '0;
      r_data_b <= '0;
    end else if (!bus.hold) begin
      if (w_bubble) begin
        r_ctrl   <= BUBBLE;
        r_alu_op <= '0;
        r_data_a <= '0;
        r_data_b <= '0;
      end else begin
        r_ctrl   <= w_ctrl_in;
        r_alu_op <= bus.alu_op_F_Reg;
        r_data_a <= bus.dataA_F_Reg;
        r_data_b <= bus.dataB_F_Reg;
      end
    end
  end

  assign bus.Ra_Reg_Exe     = r_ctrl.Ra;
  assign bus.RE_A_Reg_Exe   = r_ctrl.RE_A;
  assign bus.Rb_Reg_Exe     = r_ctrl.Rb;
  assign bus.RE_B_Reg_Exe   = r_ctrl.RE_B;
  assign bus.Robj_Reg_Exe   = r_ctrl.Robj;
  assign bus.WE_Reg_Exe     = r_ctrl.WE;
  assign bus.mem_WE_Reg_Exe = r_ctrl.mem_WE;
  assign bus.mem_RE_Reg_Exe = r_ctrl.mem_RE;
  assign bus.alu_op_Reg_Exe = r_alu_op;
  assign bus.dataA_Reg_Exe  = r_data_a;
  assign bus.dataB_Reg_Exe  = r_data_b;
  assign bus.stall          = w_stall;

endmodule
